mult_share_ctrl: RTL and testbench
==================================

# mult_share_ctrl

Sequencing controller and arbiter that shares one iterative shift-add multiplier engine between two requesters. Each operation runs one partial-product step per clock, SIZE steps total, and returns an unsigned 2*SIZE-bit product with a one-cycle done strobe to the winning requester. Round-robin arbitration stops either requester from starving the other. It sits between two independent producers of multiply jobs and the result consumers.

## Interface
- SIZE, 8, operand width in bits; product width is 2*SIZE.
- clk  in  1  rising-edge clock; all state changes on this edge.
- rst_n  in  1  reset, asynchronous and active-low.
- clr  in  1  synchronous abort/clear, active-high.
- req0  in  1  requester 0 job request; held until done0.
- a0  in  SIZE  requester 0 multiplicand.
- b0  in  SIZE  requester 0 multiplier.
- req1  in  1  requester 1 job request.
- a1  in  SIZE  requester 1 multiplicand.
- b1  in  SIZE  requester 1 multiplier.
- busy  out  1  engine owned: high in RUN and DONE.
- grant  out  1  index of the current or last owner; meaningful while busy.
- done0  out  1  one-cycle strobe: outcome holds requester 0's product.
- done1  out  1  one-cycle strobe for requester 1.
- outcome  out  2*SIZE  registered product; holds until the next completion, clr or reset.

## Operation
- States: IDLE, RUN, DONE. Internal: acc (2*SIZE), sh_a (2*SIZE), sh_b (SIZE), cnt (ceil(log2 SIZE)+1 bits), last (1 bit, owner of the previous job).
- IDLE: with no request, stay. With exactly one of req0/req1 high, grant it. With both high, grant !last. On grant, load sh_a={0,a_g}, sh_b=b_g, acc=0, cnt=0, grant=g, last=g, and go to RUN.
- RUN, each cycle: if sh_b[0], acc=acc+sh_a. Then sh_a<<=1, sh_b>>=1, cnt++. Leave for DONE on the step where cnt reaches SIZE. RUN therefore lasts exactly SIZE cycles.
- Arithmetic is unsigned. The product always fits in 2*SIZE bits, so there is no overflow or truncation.
- On the transition into DONE: outcome<=acc. In DONE: done_grant=1 for exactly one cycle, then go to IDLE.
- Operands are captured only at grant. Changes to a/b/req after grant are ignored. A requester that drops req mid-job still receives its done strobe.
- A req still high in the IDLE cycle after done counts as a new request. Round-robin alternates when both requesters are pending.
- clr, any state: next state IDLE, outcome=0, done0=done1=0, acc and counters cleared. last is unchanged. clr has priority over grant in the same cycle.
- Reset (rst_n low, asynchronous): state=IDLE, outcome=0, done0=done1=0, busy=0, grant=0, last=1 (so requester 0 wins the first tie). Internal registers are cleared. A job in flight is discarded without a done strobe.

## Timing
- Edge E0 samples req in IDLE (grant and operand load).
- Edges E1..ESIZE perform the iterations. At ESIZE the state becomes DONE and outcome is updated.
- done and the new outcome are visible in the cycle after ESIZE. The state returns to IDLE at ESIZE+1.
- Earliest next grant is ESIZE+2, so throughput is one job per SIZE+2 cycles.
- Latency from request-sampling edge to done visible is SIZE cycles, one clock after ESIZE.
- busy is high from after E0 through after ESIZE, and low after ESIZE+1.
- done0 and done1 are never high together. Neither is high outside DONE.

## Test plan
- Single job: reset, req0 with a0=15, b0=21 → busy after E0, outcome=315 with done0 one cycle after E8 (SIZE=8), done1 stays 0, busy low one cycle later.
- Tie: req0 (28×21) and req1 (15×21) both raised in the same cycle after reset → requester 0 first (outcome=588, done0), then requester 1 (outcome=315, done1). grant tracks each owner. The second done arrives 10 cycles after the first.
- Starvation: req0 held high continuously and req1 raised mid-job → grants alternate 0,1,0. outcome holds between jobs.
- Boundaries: 255×255 → 65025; 0×200 → 0; 1×255 → 255; 128×2 → 256. Each completes in exactly SIZE RUN cycles.
- Abort: clr pulsed at E4 of a 15×21 job → IDLE next cycle, outcome=0, no done. A pending req1 is granted on the following IDLE edge.
- Reset mid-job: rst_n driven low between edges at E5 → outputs go to reset values immediately, without waiting for a clock edge. After release there is no done for the aborted job, and a tie is won by requester 0.

Source files
------------

// File: rtl/mult_share_ctrl.sv
// Round-robin controller sharing one iterative shift-add multiplier between two requesters.
// Each job takes SIZE one-step iterations and returns a 2*SIZE-bit product with a one-cycle done strobe.
module mult_share_ctrl #(
   parameter int SIZE = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                req0,
   input  logic [SIZE-1:0]     a0,
   input  logic [SIZE-1:0]     b0,
   input  logic                req1,
   input  logic [SIZE-1:0]     a1,
   input  logic [SIZE-1:0]     b1,
   output logic                busy,
   output logic                grant,
   output logic                done0,
   output logic                done1,
   output logic [2*SIZE-1:0]   outcome
);

   localparam int CW = $clog2(SIZE) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state, state_next;
   logic [2*SIZE-1:0]   acc, sh_a, acc_step;
   logic [SIZE-1:0]     sh_b;
   logic [CW-1:0]       cnt;
   logic                last, grant_r;
   logic                take, pick, last_step;

   // On a tie the requester that did not own the previous job wins.
   always_comb begin
      take      = req0 | req1;
      pick      = (req0 && req1) ? ~last : req1;
      acc_step  = sh_b[0] ? (acc + sh_a) : acc;
      last_step = (cnt == CW'(SIZE - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (take) state_next = RUN;
         RUN:     if (last_step) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (clr) state_next = IDLE;
   end

   always_comb begin
      busy  = (state != IDLE);
      grant = grant_r;
      done0 = (state == DONE) && !grant_r;
      done1 = (state == DONE) &&  grant_r;
   end

   // The final step's partial product goes straight into outcome as the FSM enters DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         sh_a    <= '0;
         sh_b    <= '0;
         cnt     <= '0;
         grant_r <= 1'b0;
         last    <= 1'b1;
         outcome <= '0;
      end else if (clr) begin
         acc     <= '0;
         sh_a    <= '0;
         sh_b    <= '0;
         cnt     <= '0;
         outcome <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (take) begin
                  sh_a    <= {{SIZE{1'b0}}, (pick ? a1 : a0)};
                  sh_b    <= pick ? b1 : b0;
                  acc     <= '0;
                  cnt     <= '0;
                  grant_r <= pick;
                  last    <= pick;
               end
            end
            RUN: begin
               acc  <= acc_step;
               sh_a <= sh_a << 1;
               sh_b <= sh_b >> 1;
               cnt  <= cnt + 1'b1;
               if (last_step) outcome <= acc_step;
            end
            DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed self-checking bench for mult_share_ctrl: single jobs, ties, alternation, boundaries, clr and async reset.
module tb_mult_share_ctrl;

   localparam int SIZE = 8;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                clr = 1'b0;
   logic                req0 = 1'b0, req1 = 1'b0;
   logic [SIZE-1:0]     a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic                busy, grant, done0, done1;
   logic [2*SIZE-1:0]   outcome;

   int checks = 0;
   int failures = 0;

   mult_share_ctrl #(.SIZE(SIZE)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .req0(req0), .a0(a0), .b0(b0),
      .req1(req1), .a1(a1), .b1(b1),
      .busy(busy), .grant(grant), .done0(done0), .done1(done1),
      .outcome(outcome)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic r0, input int x0, input int y0,
                                input logic r1, input int x1, input int y1);
      req0 = r0; a0 = x0[SIZE-1:0]; b0 = y0[SIZE-1:0];
      req1 = r1; a1 = x1[SIZE-1:0]; b1 = y1[SIZE-1:0];
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Counts edges until a done strobe is seen; an expired budget is reported as a failure.
   task automatic waitDone(output int cyc, output logic which);
      cyc = 0;
      which = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         cyc++;
         if (done0 || done1) begin
            which = done1;
            return;
         end
      end
      checkOutput("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic doReset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      #4 rst_n = 1'b1;
      tick(1);
   endtask

   int   cyc;
   logic which;
   int   bnd_a [4] = '{255, 0, 1, 128};
   int   bnd_b [4] = '{255, 200, 255, 2};
   int   bnd_p [4] = '{65025, 0, 255, 256};

   initial begin
      // Reset values
      #3;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_grant", grant, 0);
      checkOutput("rst_outcome", outcome, 0);
      checkOutput("rst_done", {done0, done1}, 0);
      rst_n = 1'b1;
      tick(1);

      // Single job 15x21
      applyStimulus(1, 15, 21, 0, 0, 0);
      tick(1);
      checkOutput("single_busy_e0", busy, 1);
      checkOutput("single_grant", grant, 0);
      waitDone(cyc, which);
      checkOutput("single_latency", cyc, 8);
      checkOutput("single_done0", done0, 1);
      checkOutput("single_done1", done1, 0);
      checkOutput("single_outcome", outcome, 315);
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick(1);
      checkOutput("single_busy_after", busy, 0);
      checkOutput("single_done_clear", {done0, done1}, 0);
      checkOutput("single_hold", outcome, 315);

      // Tie after reset: requester 0 first, then requester 1 ten cycles later
      doReset();
      applyStimulus(1, 28, 21, 1, 15, 21);
      tick(1);
      checkOutput("tie_grant0", grant, 0);
      waitDone(cyc, which);
      checkOutput("tie_first_done0", done0, 1);
      checkOutput("tie_first_outcome", outcome, 588);
      req0 = 1'b0;
      waitDone(cyc, which);
      checkOutput("tie_gap", cyc, 10);
      checkOutput("tie_second_done1", done1, 1);
      checkOutput("tie_second_grant", grant, 1);
      checkOutput("tie_second_outcome", outcome, 315);
      req1 = 1'b0;
      tick(2);

      // Starvation: req0 held, req1 raised mid-job; operand change after grant is ignored
      applyStimulus(1, 3, 5, 0, 0, 0);
      tick(1);
      checkOutput("starv_grant_a", grant, 0);
      tick(3);
      applyStimulus(1, 4, 6, 1, 7, 9);
      waitDone(cyc, which);
      checkOutput("starv_first_which", which, 0);
      checkOutput("starv_first_outcome", outcome, 15);
      tick(1);
      checkOutput("starv_hold", outcome, 15);
      waitDone(cyc, which);
      checkOutput("starv_second_which", which, 1);
      checkOutput("starv_second_outcome", outcome, 63);
      req1 = 1'b0;
      waitDone(cyc, which);
      checkOutput("starv_third_which", which, 0);
      checkOutput("starv_third_outcome", outcome, 24);
      req0 = 1'b0;
      tick(2);

      // Boundary operands
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1, bnd_a[k], bnd_b[k], 0, 0, 0);
         tick(1);
         waitDone(cyc, which);
         checkOutput($sformatf("bnd%0d_latency", k), cyc, 8);
         checkOutput($sformatf("bnd%0d_outcome", k), outcome, bnd_p[k]);
         req0 = 1'b0;
         tick(1);
      end

      // Abort with clr at E4, pending req1 granted next
      applyStimulus(1, 15, 21, 0, 0, 0);
      tick(1);
      applyStimulus(0, 0, 0, 1, 7, 9);
      tick(3);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      checkOutput("clr_busy", busy, 0);
      checkOutput("clr_outcome", outcome, 0);
      checkOutput("clr_done", {done0, done1}, 0);
      tick(1);
      checkOutput("clr_regrant_busy", busy, 1);
      checkOutput("clr_regrant_grant", grant, 1);
      waitDone(cyc, which);
      checkOutput("clr_next_which", which, 1);
      checkOutput("clr_next_latency", cyc, 8);
      checkOutput("clr_next_outcome", outcome, 63);
      req1 = 1'b0;
      tick(2);

      // Async reset mid-job, then a tie is won by requester 0
      applyStimulus(0, 0, 0, 1, 15, 21);
      tick(1);
      checkOutput("mrst_grant_before", grant, 1);
      tick(4);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mrst_busy", busy, 0);
      checkOutput("mrst_grant", grant, 0);
      checkOutput("mrst_outcome", outcome, 0);
      checkOutput("mrst_done", {done0, done1}, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick(1);
      applyStimulus(1, 2, 3, 1, 5, 5);
      tick(1);
      checkOutput("mrst_tie_grant", grant, 0);
      waitDone(cyc, which);
      checkOutput("mrst_tie_which", which, 0);
      checkOutput("mrst_tie_latency", cyc, 8);
      checkOutput("mrst_tie_outcome", outcome, 6);
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
